low_power_issue_unit: RTL and testbench
=======================================

LOW_POWER_ISSUE_UNIT -- requirements
Module: low_power_issue_unit

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, the instruction buffer depth (power of two, 2..16).
REQ-002 The module SHALL have parameter IDLE_CYCLES, default 8, the number of consecutive idle cycles before sleep (range 1..255).
REQ-003 Port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port in_valid, input, 1 bit: the upstream instruction is present.
REQ-006 Port in_opcode, input, 3 bits: the upstream opcode.
REQ-007 Port in_ready, output, 1 bit: the unit can accept an instruction this cycle.
REQ-008 Port issue_stall, input, 1 bit: the downstream control unit cannot take an instruction this cycle.
REQ-009 Port opcode, output, 3 bits: the opcode issued to the control unit.
REQ-010 Port valid, output, 1 bit: opcode is a live instruction this cycle.
REQ-011 Port sleep_req, output, 1 bit: the low-power sleep request.
REQ-012 Port err_illegal, output, 1 bit: a one-cycle pulse when an illegal opcode is dropped.

Function
REQ-013 Opcode encoding SHALL be NOP=000, ADD=001, SUB=010, AND=011, OR=100; 101..111 are illegal.
REQ-014 A transfer SHALL occur on a rising edge where in_valid && in_ready; the opcode is then written to the FIFO tail.
REQ-015 An illegal opcode SHALL be accepted, SHALL NOT be written to the FIFO, and SHALL pulse err_illegal on the following cycle.
REQ-016 in_ready SHALL equal !full && (state != SLEEP) and SHALL be combinational from registered state only.
REQ-017 The FSM SHALL have states ACTIVE, IDLE, and SLEEP; the reset state is ACTIVE.
REQ-018 In ACTIVE or IDLE, when the FIFO is non-empty and issue_stall=0, the head SHALL pop and be registered to opcode with valid=1 on the next cycle.
REQ-019 The minimum latency SHALL be one cycle: an accept at edge N produces valid=1 after edge N+1. There is no same-cycle bypass.
REQ-020 valid SHALL be high for exactly one cycle per issued instruction; while issue_stall=1, no pop occurs and valid=0.
REQ-021 When valid=0, opcode SHALL hold its last issued value, to limit toggling.
REQ-022 A simultaneous push and pop while full SHALL NOT occur, because in_ready=0 when full.
REQ-023 A simultaneous push and pop at any other occupancy SHALL leave occupancy unchanged.
REQ-024 The FIFO pointers SHALL wrap modulo DEPTH; occupancy SHALL use a $clog2(DEPTH)+1 bit counter.
REQ-025 ACTIVE SHALL go to IDLE when the FIFO is empty, in_valid=0, and valid=0.
REQ-026 IDLE SHALL increment an 8-bit idle counter each cycle.
REQ-027 Any in_valid, or a non-empty FIFO, SHALL clear the idle counter and return the FSM to ACTIVE.
REQ-028 IDLE SHALL go to SLEEP on the cycle the idle counter reaches IDLE_CYCLES-1.
REQ-029 In SLEEP, sleep_req SHALL be 1, in_ready SHALL be 0, and valid SHALL be 0.
REQ-030 In SLEEP, in_valid=1 SHALL cause a return to ACTIVE on the next edge, with sleep_req=0 and in_ready=1 from that cycle onward.

Reset
REQ-031 Asserting rst_n=0 SHALL asynchronously force all of the following, at any time including mid-transfer:
- opcode=000, valid=0, sleep_req=0, err_illegal=0;
- FIFO empty, both pointers 0;
- idle counter 0;
- state ACTIVE.
REQ-032 Instructions buffered when reset asserts SHALL be discarded.
REQ-033 in_ready SHALL be 1 in the first cycle after deassertion.

Configuration
REQ-034 The unit SHALL support the macro ISSUE_NOP_FILTER_EN.
- Defined: accepted NOP opcodes are dropped like illegal opcodes, but without err_illegal, so NOPs never issue.
- Undefined: NOP is buffered and issued like any legal opcode.

Structure
REQ-035 The shared package lp_ctrl_pkg SHALL hold:
- the opcode_t enum (NOP, ADD, SUB, AND, OR);
- the issue FSM state enum;
- the is_legal_opcode function.
The existing control unit SHALL import the same package.
REQ-036 The sub-module lp_issue_fifo (parameterised DEPTH, WIDTH=3, with full/empty/count) SHALL hold the buffer; the FSM and output register SHALL stay in the top module.

Verification
REQ-037 Reset, then push ADD at cycle 3 with issue_stall=0 -> valid=1, opcode=001 exactly one cycle later, then valid=0 with opcode holding 001.
REQ-038 With issue_stall=1, push ADD, SUB, AND, OR (DEPTH=4) -> in_ready=0 after the fourth accept; then release the stall -> valid on 4 consecutive cycles with opcodes 001, 010, 011, 100 in order.
REQ-039 Push 110 -> err_illegal pulses once, valid never rises, and FIFO occupancy stays 0.
REQ-040 Idle with IDLE_CYCLES=8 -> sleep_req=1 after 8 idle cycles with in_ready=0; then in_valid=1 with SUB -> sleep_req=0 next cycle, SUB is accepted once in_ready=1, and valid=1 with opcode=010 one cycle after acceptance.
REQ-041 With 3 instructions buffered, assert rst_n=0 asynchronously mid-cycle -> valid=0 immediately, and no buffered instruction issues after release.
REQ-042 Push NOP -> valid=1 with opcode=000 when ISSUE_NOP_FILTER_EN is undefined; no issue and no err_illegal when it is defined.

Source files
------------

// File: rtl/lp_ctrl_pkg.sv
// Shared opcode, issue-FSM state and legality helper for the issue unit and the control unit.
package lp_ctrl_pkg;

  localparam int unsigned OPCODE_W   = 3;
  localparam int unsigned IDLE_CNT_W = 8;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100
  } opcode_t;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_IDLE   = 2'd1,
    ST_SLEEP  = 2'd2
  } issue_state_t;

  // Encodings above OR are reserved and must never reach the control unit.
  function automatic logic is_legal_opcode(input logic [OPCODE_W-1:0] op);
    return op <= OPCODE_W'(OP_OR);
  endfunction

endpackage

// File: rtl/lp_issue_fifo.sv
// Instruction buffer for the issue unit: power-of-two circular FIFO with registered full/empty/count.
module lp_issue_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CNT_W'(DEPTH));
      empty_q  <= (count_d == '0);
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/low_power_issue_unit.sv
// Buffered instruction issue with idle detection and sleep request.
// Optional macro ISSUE_NOP_FILTER_EN: silently drop accepted NOPs instead of issuing them.
module low_power_issue_unit
  import lp_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned IDLE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [2:0] in_opcode,
  output logic       in_ready,
  input  logic       issue_stall,
  output logic [2:0] opcode,
  output logic       valid,
  output logic       sleep_req,
  output logic       err_illegal
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  issue_state_t          state_q, state_d;
  logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [OPCODE_W-1:0]   opcode_q, opcode_d;
  logic                  valid_q, valid_d;
  logic                  sleep_q, sleep_d;
  logic                  err_q, err_d;

  logic                  accept, push, pop, drop_nop, fifo_busy;
  logic                  fifo_full, fifo_empty;
  logic [OPCODE_W-1:0]   fifo_head;
  logic [CNT_W-1:0]      fifo_count;

`ifdef ISSUE_NOP_FILTER_EN
  assign drop_nop = (in_opcode == OPCODE_W'(OP_NOP));
`else
  assign drop_nop = 1'b0;
`endif

  assign in_ready  = !fifo_full && (state_q != ST_SLEEP);
  assign accept    = in_valid && in_ready;
  assign push      = accept && is_legal_opcode(in_opcode) && !drop_nop;
  assign pop       = (state_q != ST_SLEEP) && !fifo_empty && !issue_stall;
  assign fifo_busy = (fifo_count != '0);

  lp_issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (OPCODE_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (in_opcode),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Next-state and output-register logic.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    valid_d    = pop;
    opcode_d   = pop ? fifo_head : opcode_q;
    err_d      = accept && !is_legal_opcode(in_opcode);

    unique case (state_q)
      ST_ACTIVE: begin
        idle_cnt_d = '0;
        if (!fifo_busy && !in_valid && !valid_q) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (in_valid || fifo_busy) begin
          state_d    = ST_ACTIVE;
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_CNT_W'(IDLE_CYCLES - 1)) begin
          state_d    = ST_SLEEP;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_CNT_W'(1);
        end
      end
      ST_SLEEP: begin
        if (in_valid) state_d = ST_ACTIVE;
      end
      default: state_d = ST_ACTIVE;
    endcase

    sleep_d = (state_d == ST_SLEEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ACTIVE;
      idle_cnt_q <= '0;
      opcode_q   <= '0;
      valid_q    <= 1'b0;
      sleep_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      opcode_q   <= opcode_d;
      valid_q    <= valid_d;
      sleep_q    <= sleep_d;
      err_q      <= err_d;
    end
  end

  assign opcode      = opcode_q;
  assign valid       = valid_q;
  assign sleep_req   = sleep_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_low_power_issue_unit.sv
// Self-checking bench for low_power_issue_unit: queue-based reference model, directed scenarios, random traffic.
module tb_low_power_issue_unit;

  localparam int unsigned DEPTH       = 4;
  localparam int unsigned IDLE_CYCLES = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_opcode = 3'd0;
  logic       issue_stall = 1'b0;
  logic       in_ready, valid, sleep_req, err_illegal;
  logic [2:0] opcode;

  int checks = 0;
  int errors = 0;

  low_power_issue_unit #(
    .DEPTH       (DEPTH),
    .IDLE_CYCLES (IDLE_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_opcode   (in_opcode),
    .in_ready    (in_ready),
    .issue_stall (issue_stall),
    .opcode      (opcode),
    .valid       (valid),
    .sleep_req   (sleep_req),
    .err_illegal (err_illegal)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of buffered opcodes plus a run-length of quiet edges.
  logic [2:0] m_q[$];
  logic       m_valid = 1'b0;
  logic [2:0] m_op = 3'd0;
  logic       m_err = 1'b0;
  logic       m_sleep = 1'b0;
  int         m_quiet = 0;

  function automatic logic m_ready();
    return (m_q.size() < int'(DEPTH)) && !m_sleep;
  endfunction

  function automatic logic nop_filtered(input logic [2:0] op);
`ifdef ISSUE_NOP_FILTER_EN
    return op == 3'd0;
`else
    return 1'b0 && (op == 3'd0);
`endif
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_valid = 1'b0;
    m_op    = 3'd0;
    m_err   = 1'b0;
    m_sleep = 1'b0;
    m_quiet = 0;
  endtask

  // A quiet edge: nothing buffered, nothing offered, nothing issued. IDLE_CYCLES+1 of them in a row
  // (one to leave ACTIVE, then IDLE_CYCLES counted idle cycles) put the unit to sleep.
  task automatic model_edge();
    logic acc, quiet, legal;
    acc   = in_valid && m_ready();
    quiet = (m_q.size() == 0) && !in_valid && !m_valid;
    legal = (in_opcode <= 3'd4);
    m_err = acc && !legal;
    if (!m_sleep && m_q.size() > 0 && !issue_stall) begin
      m_op    = m_q.pop_front();
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (acc && legal && !nop_filtered(in_opcode)) m_q.push_back(in_opcode);
    if (m_sleep) begin
      if (in_valid) m_sleep = 1'b0;
      m_quiet = 0;
    end else if (quiet) begin
      m_quiet++;
      if (m_quiet == int'(IDLE_CYCLES) + 1) begin
        m_sleep = 1'b1;
        m_quiet = 0;
      end
    end else begin
      m_quiet = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled away from the rising edge.
  always @(negedge clk) begin
    chk("in_ready",    32'(in_ready),    32'(m_ready()));
    chk("valid",       32'(valid),       32'(m_valid));
    chk("opcode",      32'(opcode),      32'(m_op));
    chk("sleep_req",   32'(sleep_req),   32'(m_sleep));
    chk("err_illegal", 32'(err_illegal), 32'(m_err));
  end

  task automatic step(input logic v, input logic [2:0] op, input logic st);
    in_valid    = v;
    in_opcode   = op;
    issue_stall = st;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_opcode   = 3'd0;
    issue_stall = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int vcount;

  initial begin
    model_reset();
    do_reset();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_valid",    32'(valid),    32'd0);
    chk("rst_opcode",   32'(opcode),   32'd0);
    chk("rst_sleep",    32'(sleep_req), 32'd0);

    // Single ADD: one-cycle latency, single-cycle valid, opcode holds.
    step(1'b1, 3'd1, 1'b0);
    chk("add_lat0_valid", 32'(valid), 32'd0);
    step(1'b0, 3'd0, 1'b0);
    chk("add_valid",  32'(valid),  32'd1);
    chk("add_opcode", 32'(opcode), 32'd1);
    step(1'b0, 3'd0, 1'b0);
    chk("add_drop_valid",  32'(valid),  32'd0);
    chk("add_hold_opcode", 32'(opcode), 32'd1);

    // Fill under stall, then drain in order.
    for (int i = 1; i <= 4; i++) step(1'b1, 3'(i), 1'b1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 3'd0, 1'b0);
      chk("drain_valid",  32'(valid),  32'd1);
      chk("drain_opcode", 32'(opcode), 32'(i));
    end
    step(1'b0, 3'd0, 1'b0);
    chk("drain_end_valid", 32'(valid), 32'd0);

    // Illegal opcode is swallowed with a single error pulse.
    step(1'b1, 3'd6, 1'b0);
    chk("ill_err",   32'(err_illegal), 32'd1);
    chk("ill_valid", 32'(valid),       32'd0);
    step(1'b0, 3'd0, 1'b0);
    chk("ill_err_once", 32'(err_illegal), 32'd0);
    chk("ill_valid2",   32'(valid),       32'd0);
    chk("ill_occupancy", 32'(dut.u_fifo.count_o), 32'd0);

    // Sleep entry from reset, then wake with SUB.
    do_reset();
    for (int i = 0; i < int'(IDLE_CYCLES); i++) step(1'b0, 3'd0, 1'b0);
    chk("pre_sleep", 32'(sleep_req), 32'd0);
    step(1'b0, 3'd0, 1'b0);
    chk("sleep_req",      32'(sleep_req), 32'd1);
    chk("sleep_in_ready", 32'(in_ready),  32'd0);
    step(1'b1, 3'd2, 1'b0);
    chk("wake_sleep", 32'(sleep_req), 32'd0);
    chk("wake_ready", 32'(in_ready),  32'd1);
    chk("wake_valid", 32'(valid),     32'd0);
    step(1'b1, 3'd2, 1'b0);
    chk("wake_acc_valid", 32'(valid), 32'd0);
    step(1'b0, 3'd0, 1'b0);
    chk("wake_sub_valid",  32'(valid),  32'd1);
    chk("wake_sub_opcode", 32'(opcode), 32'd2);

    // Mid-cycle asynchronous reset with instructions buffered and one issuing.
    for (int i = 1; i <= 4; i++) step(1'b1, 3'(i), 1'b1);
    step(1'b0, 3'd0, 1'b0);
    chk("pre_rst_valid", 32'(valid), 32'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_valid",  32'(valid),  32'd0);
    chk("async_rst_opcode", 32'(opcode), 32'd0);
    do_reset();
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 3'd0, 1'b0);
      if (valid) vcount++;
    end
    chk("post_rst_no_issue", 32'(vcount), 32'd0);

    // NOP handling depends on the filter build option.
    step(1'b1, 3'd1, 1'b0);
    step(1'b1, 3'd0, 1'b0);
    step(1'b0, 3'd0, 1'b0);
`ifdef ISSUE_NOP_FILTER_EN
    chk("nop_valid",  32'(valid),       32'd0);
    chk("nop_opcode", 32'(opcode),      32'd1);
    chk("nop_err",    32'(err_illegal), 32'd0);
`else
    chk("nop_valid",  32'(valid),  32'd1);
    chk("nop_opcode", 32'(opcode), 32'd0);
`endif

    // Random bursts with varying density, stall rate and occasional resets.
    for (int b = 0; b < 80; b++) begin
      int dens, len, stp;
      dens = (b % 3 == 0) ? 0 : int'($urandom_range(10, 100));
      len  = int'($urandom_range(5, 30));
      stp  = int'($urandom_range(0, 60));
      for (int i = 0; i < len; i++) begin
        step(int'($urandom_range(0, 99)) < dens, 3'($urandom_range(0, 7)),
             int'($urandom_range(0, 99)) < stp);
      end
      if ($urandom_range(0, 15) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        do_reset();
      end
    end

    step(1'b0, 3'd0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
